// File: rtl/stack_cpu_ctrl_p.sv
// ---------------------------------------------------------------------------
// stack_cpu_ctrl_p
// Control unit for the stack-machine CPU. Fetches instructions from a
// synchronous instruction RAM, sequences the data stack, the data RAM and an
// external combinational ALU, keeps a RET_DEPTH-entry return-address stack
// for CALL/RET, and reports sticky faults.
//
// Ports
//   clk, reset                        clock, synchronous active-high reset
//   imem_en/imem_addr/imem_rdata      instruction RAM (1-cycle read latency)
//   dmem_en/we/addr/wdata/rdata       data RAM (1-cycle read latency)
//   stk_push/stk_pop/stk_wdata        data-stack strobes, applied at the edge
//   stk_top/stk_full/stk_empty        combinational data-stack view
//   alu_op/alu_a/alu_b/alu_result     combinational ALU
//   ip                                instruction pointer
//   halted/fault/fault_code           status
// ---------------------------------------------------------------------------
module stack_cpu_ctrl_p #(
    parameter int DATA_W    = 8,
    parameter int ADDR_W    = 8,
    parameter int OP_W      = 5,
    parameter int RET_DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     reset,
    output logic                     imem_en,
    output logic [ADDR_W-1:0]        imem_addr,
    input  logic [OP_W+ADDR_W-1:0]   imem_rdata,
    output logic                     dmem_en,
    output logic                     dmem_we,
    output logic [ADDR_W-1:0]        dmem_addr,
    output logic [DATA_W-1:0]        dmem_wdata,
    input  logic [DATA_W-1:0]        dmem_rdata,
    output logic                     stk_push,
    output logic                     stk_pop,
    output logic [DATA_W-1:0]        stk_wdata,
    input  logic [DATA_W-1:0]        stk_top,
    input  logic                     stk_full,
    input  logic                     stk_empty,
    output logic [OP_W-1:0]          alu_op,
    output logic [DATA_W-1:0]        alu_a,
    output logic [DATA_W-1:0]        alu_b,
    input  logic [DATA_W-1:0]        alu_result,
    output logic [ADDR_W-1:0]        ip,
    output logic                     halted,
    output logic                     fault,
    output logic [2:0]               fault_code
);

    localparam int RSP_W = $clog2(RET_DEPTH + 1);

    localparam logic [OP_W-1:0] OP_PUSH   = OP_W'(0);
    localparam logic [OP_W-1:0] OP_PUSH_I = OP_W'(1);
    localparam logic [OP_W-1:0] OP_PUSH_T = OP_W'(2);
    localparam logic [OP_W-1:0] OP_POP    = OP_W'(3);
    localparam logic [OP_W-1:0] OP_ADD    = OP_W'(4);
    localparam logic [OP_W-1:0] OP_CMP    = OP_W'(12);
    localparam logic [OP_W-1:0] OP_NOT    = OP_W'(13);
    localparam logic [OP_W-1:0] OP_GOTO   = OP_W'(14);
    localparam logic [OP_W-1:0] OP_IF_EQ  = OP_W'(15);
    localparam logic [OP_W-1:0] OP_IF_GT  = OP_W'(16);
    localparam logic [OP_W-1:0] OP_IF_LT  = OP_W'(17);
    localparam logic [OP_W-1:0] OP_IF_GE  = OP_W'(18);
    localparam logic [OP_W-1:0] OP_IF_LE  = OP_W'(19);
    localparam logic [OP_W-1:0] OP_CALL   = OP_W'(20);
    localparam logic [OP_W-1:0] OP_RET    = OP_W'(21);
    localparam logic [OP_W-1:0] OP_HALT   = OP_W'(22);

    localparam logic [2:0] FC_STK_EMPTY = 3'd1;
    localparam logic [2:0] FC_STK_FULL  = 3'd2;
    localparam logic [2:0] FC_RET_FULL  = 3'd3;
    localparam logic [2:0] FC_RET_EMPTY = 3'd4;
    localparam logic [2:0] FC_BAD_OP    = 3'd5;

    typedef enum logic [3:0] {
        S_RESET, S_FETCH, S_DECODE, S_POP_A, S_POP_B,
        S_MEM_RD, S_PUSH, S_BRANCH, S_HALT, S_FAULT
    } state_t;

    // Binary ALU ops occupy the contiguous opcode range ADD..CMP.
    function automatic logic is_binop(input logic [OP_W-1:0] op);
        return (op >= OP_ADD) && (op <= OP_CMP);
    endfunction

    function automatic logic is_cond(input logic [OP_W-1:0] op);
        return (op >= OP_IF_EQ) && (op <= OP_IF_LE);
    endfunction

    // CMP result: 0 = equal, 1 = greater, all-ones = less.
    function automatic logic cond_taken(input logic [OP_W-1:0] op,
                                        input logic [DATA_W-1:0] res);
        logic eq, gt, lt;
        eq = (res == '0);
        gt = (res == DATA_W'(1));
        lt = (res == '1);
        case (op)
            OP_IF_EQ: cond_taken = eq;
            OP_IF_GT: cond_taken = gt;
            OP_IF_LT: cond_taken = lt;
            OP_IF_GE: cond_taken = eq | gt;
            OP_IF_LE: cond_taken = eq | lt;
            default:  cond_taken = 1'b0;
        endcase
    endfunction

    state_t             state_q, state_d;
    logic [ADDR_W-1:0]  ip_q, ip_d;
    logic [OP_W-1:0]    ir_q, ir_d;
    logic [ADDR_W-1:0]  opd_q, opd_d;
    logic [DATA_W-1:0]  a_q, a_d;
    logic [DATA_W-1:0]  b_q, b_d;
    logic [DATA_W-1:0]  t_q, t_d;
    logic [2:0]         fault_code_q, fault_code_d;
    logic [RSP_W-1:0]   rsp_q, rsp_d;
    logic [ADDR_W-1:0]  ret_q [RET_DEPTH];

    logic               ret_push, ret_pop;
    logic [ADDR_W-1:0]  ip_inc;
    logic [ADDR_W-1:0]  target;
    logic [OP_W-1:0]    dec_op;
    logic [ADDR_W-1:0]  dec_opd;
    logic [DATA_W-1:0]  push_val;
    logic               push_is_alu;

    assign ip_inc     = ip_q + 1'b1;
    assign target     = ADDR_W'(dmem_rdata);
    assign dec_op     = imem_rdata[OP_W+ADDR_W-1 -: OP_W];
    assign dec_opd    = imem_rdata[ADDR_W-1:0];
    assign ip         = ip_q;
    assign fault_code = fault_code_q;

    always_comb begin
        state_d      = state_q;
        ip_d         = ip_q;
        ir_d         = ir_q;
        opd_d        = opd_q;
        a_d          = a_q;
        b_d          = b_q;
        t_d          = t_q;
        fault_code_d = fault_code_q;
        rsp_d        = rsp_q;
        ret_push     = 1'b0;
        ret_pop      = 1'b0;
        push_val     = '0;
        push_is_alu  = 1'b0;
        imem_en      = 1'b0;
        imem_addr    = '0;
        dmem_en      = 1'b0;
        dmem_we      = 1'b0;
        dmem_addr    = '0;
        dmem_wdata   = '0;
        stk_push     = 1'b0;
        stk_pop      = 1'b0;
        stk_wdata    = '0;
        alu_op       = '0;
        alu_a        = '0;
        alu_b        = '0;
        halted       = 1'b0;
        fault        = 1'b0;

        // Reset masks every strobe combinationally so a pending stack or
        // memory operation is dropped at the reset edge itself.
        if (!reset) begin
            case (state_q)
                S_RESET: state_d = S_FETCH;

                S_FETCH: begin
                    imem_en   = 1'b1;
                    imem_addr = ip_q;
                    state_d   = S_DECODE;
                end

                S_DECODE: begin
                    ir_d  = dec_op;
                    opd_d = dec_opd;
                    if (dec_op == OP_PUSH_I || dec_op == OP_PUSH_T) begin
                        state_d = S_PUSH;
                    end else if (dec_op == OP_PUSH || dec_op == OP_GOTO ||
                                 dec_op == OP_CALL) begin
                        state_d = S_MEM_RD;
                    end else if (dec_op == OP_POP || dec_op == OP_NOT ||
                                 is_binop(dec_op) || is_cond(dec_op)) begin
                        state_d = S_POP_A;
                    end else if (dec_op == OP_RET) begin
                        state_d = S_BRANCH;
                    end else if (dec_op == OP_HALT) begin
                        state_d = S_HALT;
                    end else begin
                        fault_code_d = FC_BAD_OP;
                        state_d      = S_FAULT;
                    end
                end

                S_POP_A: begin
                    if (stk_empty) begin
                        fault_code_d = FC_STK_EMPTY;
                        state_d      = S_FAULT;
                    end else begin
                        stk_pop = 1'b1;
                        a_d     = stk_top;
                        if (ir_q == OP_POP) begin
                            dmem_en    = 1'b1;
                            dmem_we    = 1'b1;
                            dmem_addr  = opd_q;
                            dmem_wdata = stk_top;
                            ip_d       = ip_inc;
                            state_d    = S_FETCH;
                        end else if (ir_q == OP_NOT) begin
                            state_d = S_PUSH;
                        end else if (is_cond(ir_q)) begin
                            state_d = S_MEM_RD;
                        end else begin
                            state_d = S_POP_B;
                        end
                    end
                end

                S_POP_B: begin
                    if (stk_empty) begin
                        fault_code_d = FC_STK_EMPTY;
                        state_d      = S_FAULT;
                    end else begin
                        stk_pop = 1'b1;
                        b_d     = stk_top;
                        state_d = S_PUSH;
                    end
                end

                S_MEM_RD: begin
                    dmem_en   = 1'b1;
                    dmem_addr = opd_q;
                    state_d   = (ir_q == OP_PUSH) ? S_PUSH : S_BRANCH;
                end

                S_PUSH: begin
                    if (ir_q == OP_PUSH_I) begin
                        push_val = DATA_W'(opd_q);
                    end else if (ir_q == OP_PUSH_T) begin
                        push_val = t_q;
                    end else if (ir_q == OP_PUSH) begin
                        push_val = dmem_rdata;
                    end else begin
                        // NOT is unary on A; binary ops take B (deeper) op A (top).
                        push_is_alu = 1'b1;
                        alu_op      = ir_q;
                        alu_a       = (ir_q == OP_NOT) ? a_q : b_q;
                        alu_b       = (ir_q == OP_NOT) ? '0 : a_q;
                        push_val    = alu_result;
                    end
                    if (stk_full) begin
                        fault_code_d = FC_STK_FULL;
                        state_d      = S_FAULT;
                    end else begin
                        stk_push  = 1'b1;
                        stk_wdata = push_val;
                        if (push_is_alu) t_d = alu_result;
                        ip_d    = ip_inc;
                        state_d = S_FETCH;
                    end
                end

                S_BRANCH: begin
                    state_d = S_FETCH;
                    if (ir_q == OP_GOTO) begin
                        ip_d = target;
                    end else if (ir_q == OP_CALL) begin
                        if (rsp_q == RSP_W'(RET_DEPTH)) begin
                            fault_code_d = FC_RET_FULL;
                            state_d      = S_FAULT;
                        end else begin
                            ret_push = 1'b1;
                            rsp_d    = rsp_q + 1'b1;
                            ip_d     = target;
                        end
                    end else if (ir_q == OP_RET) begin
                        if (rsp_q == '0) begin
                            fault_code_d = FC_RET_EMPTY;
                            state_d      = S_FAULT;
                        end else begin
                            ret_pop = 1'b1;
                            rsp_d   = rsp_q - 1'b1;
                            ip_d    = ret_q[0];
                        end
                    end else begin
                        alu_op = OP_CMP;
                        alu_a  = a_q;
                        alu_b  = '0;
                        ip_d   = cond_taken(ir_q, alu_result) ? target : ip_inc;
                    end
                end

                S_HALT:  halted = 1'b1;

                S_FAULT: fault = 1'b1;

                default: state_d = S_RESET;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= S_RESET;
            ip_q         <= '0;
            ir_q         <= '0;
            opd_q        <= '0;
            a_q          <= '0;
            b_q          <= '0;
            t_q          <= '0;
            fault_code_q <= '0;
            rsp_q        <= '0;
        end else begin
            state_q      <= state_d;
            ip_q         <= ip_d;
            ir_q         <= ir_d;
            opd_q        <= opd_d;
            a_q          <= a_d;
            b_q          <= b_d;
            t_q          <= t_d;
            fault_code_q <= fault_code_d;
            rsp_q        <= rsp_d;
        end
    end

    // Return stack is a shift register: entry 0 is always the top, so no
    // pointer-indexed access is needed. Occupancy lives in rsp_q.
    always_ff @(posedge clk) begin
        if (ret_push) begin
            ret_q[0] <= ip_inc;
            for (int i = 1; i < RET_DEPTH; i++) ret_q[i] <= ret_q[i-1];
        end else if (ret_pop) begin
            for (int i = 0; i < RET_DEPTH - 1; i++) ret_q[i] <= ret_q[i+1];
        end
    end

endmodule
